// File: rtl/chord_mixer_if.sv
// Voice-bank/codec bus of the chord mixer: request, voice captures, mixed result and status.
interface chord_mixer_if #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 16
);
    logic                           play_enable;
    logic                           generate_next_sample;
    logic [NUM_VOICES-1:0]          voice_active;
    logic [NUM_VOICES-1:0]          voice_ready;
    logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples;
    logic [SAMPLE_W-1:0]            sample_out;
    logic                           new_sample_ready;
    logic [NUM_VOICES-1:0]          missed_mask;
    logic                           overrun;

    modport master (
        output play_enable, generate_next_sample, voice_active, voice_ready, voice_samples,
        input  sample_out, new_sample_ready, missed_mask, overrun
    );

    modport slave (
        input  play_enable, generate_next_sample, voice_active, voice_ready, voice_samples,
        output sample_out, new_sample_ready, missed_mask, overrun
    );
endinterface

// File: rtl/chord_mixer.sv
// N-voice sequential sample mixer with per-voice timeout; one mixed sample per codec request.
// Optional MIX_SATURATE_EN: sum unscaled samples in a wider accumulator and clamp instead of pre-shifting.
//
// state   | meaning
// IDLE    | waiting for generate_next_sample
// COLLECT | capturing voice samples until all active voices are in or the timer expires
// SUM     | adding one voice per cycle, index 0..NUM_VOICES-1
// OUT     | one-cycle new_sample_ready with the mixed result
module chord_mixer #(
    parameter int NUM_VOICES     = 3,
    parameter int SAMPLE_W       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    chord_mixer_if.slave bus
);
    localparam int SHIFT = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef MIX_SATURATE_EN
    localparam int ACC_W = SAMPLE_W + SHIFT;
`else
    localparam int ACC_W = SAMPLE_W;
`endif
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SUM, OUT} state_t;

    state_t                     state_q, state_d;
    logic [NUM_VOICES-1:0]      act_q, cap_mask_q, missed_q;
    logic signed [SAMPLE_W-1:0] cap_q [NUM_VOICES];
    logic [TMR_W-1:0]           timer_q;
    logic [IDX_W-1:0]           idx_q;
    logic signed [ACC_W-1:0]    acc_q, term;
    logic signed [SAMPLE_W-1:0] mix, mix_gated, sample_q;
    logic                       overrun_q;
    logic                       accept, capture_en, all_in, timed_out;

    assign accept     = (state_q == IDLE) && bus.generate_next_sample;
    assign capture_en = accept || (state_q == COLLECT);
    assign all_in     = ((cap_mask_q & act_q) == act_q);
    assign timed_out  = (timer_q == '0);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.generate_next_sample) state_d = COLLECT;
            COLLECT: if (all_in || timed_out)      state_d = SUM;
            SUM:     if (idx_q == IDX_LAST)        state_d = OUT;
            OUT:                                   state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // Voices that were not captured or are not playing contribute nothing.
    always_comb begin
        term = '0;
        if (cap_mask_q[idx_q] && act_q[idx_q]) begin
`ifdef MIX_SATURATE_EN
            term = ACC_W'(cap_q[idx_q]);
`else
            term = cap_q[idx_q] >>> SHIFT;
`endif
        end
    end

`ifdef MIX_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(SHIFT + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(SHIFT + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

    always_comb begin
        if (acc_q > SAT_MAX)      mix = SAT_MAX[SAMPLE_W-1:0];
        else if (acc_q < SAT_MIN) mix = SAT_MIN[SAMPLE_W-1:0];
        else                      mix = acc_q[SAMPLE_W-1:0];
    end
`else
    assign mix = acc_q;
`endif

    assign mix_gated = bus.play_enable ? mix : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q      <= '0;
            cap_mask_q <= '0;
            timer_q    <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            sample_q   <= '0;
            missed_q   <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) cap_q[i] <= '0;
        end else begin
            if (bus.generate_next_sample && (state_q != IDLE)) overrun_q <= 1'b1;

            for (int i = 0; i < NUM_VOICES; i++) begin
                if (capture_en && bus.voice_ready[i])
                    cap_q[i] <= bus.voice_samples[i*SAMPLE_W +: SAMPLE_W];
            end

            case (state_q)
                IDLE: begin
                    if (bus.generate_next_sample) begin
                        act_q      <= bus.voice_active;
                        cap_mask_q <= bus.voice_ready;
                        timer_q    <= TMR_LOAD;
                        idx_q      <= '0;
                        acc_q      <= '0;
                    end
                end
                COLLECT: begin
                    cap_mask_q <= cap_mask_q | bus.voice_ready;
                    if (!timed_out) timer_q <= timer_q - 1'b1;
                end
                SUM: begin
                    acc_q <= acc_q + term;
                    idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
                OUT: begin
                    sample_q <= mix_gated;
                    missed_q <= act_q & ~cap_mask_q;
                end
                default: ;
            endcase
        end
    end

    // In OUT the fresh result is driven directly so it is valid in the pulse cycle.
    always_comb begin
        bus.new_sample_ready = (state_q == OUT);
        bus.sample_out       = sample_q;
        bus.missed_mask      = missed_q;
        bus.overrun          = overrun_q;
        if (state_q == OUT) begin
            bus.sample_out  = mix_gated;
            bus.missed_mask = act_q & ~cap_mask_q;
        end
    end
endmodule

// File: tb/tb_chord_mixer.sv
// Directed bench for chord_mixer (3 voices, 16-bit, timeout 64); expectations follow MIX_SATURATE_EN.
module tb_chord_mixer;
    localparam int NV = 3;
    localparam int SW = 16;

`ifdef MIX_SATURATE_EN
    localparam logic [15:0] EXP1 = 16'h7FFF;
    localparam logic [15:0] EXP2 = 16'hFFF4;
    localparam logic [15:0] EXP3 = 16'h0C00;
    localparam logic [15:0] EXP4 = 16'h7FFC;
    localparam logic [15:0] EXP5 = 16'h6000;
`else
    localparam logic [15:0] EXP1 = 16'h3000;
    localparam logic [15:0] EXP2 = 16'hFFFD;
    localparam logic [15:0] EXP3 = 16'h0300;
    localparam logic [15:0] EXP4 = 16'h1FFF;
    localparam logic [15:0] EXP5 = 16'h1800;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chord_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW)) bus ();

    chord_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [47:0] smp3(input logic [15:0] v0, input logic [15:0] v1,
                                         input logic [15:0] v2);
        return {v2, v1, v0};
    endfunction

    task automatic start_request(input logic [2:0] act, input logic [2:0] rdy,
                                 input logic [47:0] smp, output int q);
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        bus.voice_active         = act;
        bus.voice_ready          = rdy;
        bus.voice_samples        = smp;
        q = cyc;
    endtask

    task automatic present(input logic [2:0] rdy, input logic [47:0] smp);
        @(negedge clk);
        bus.generate_next_sample = 1'b0;
        bus.voice_ready          = rdy;
        bus.voice_samples        = smp;
    endtask

    task automatic wait_pulse(input int budget, output bit got, output int at,
                              output logic [15:0] s, output logic [2:0] m);
        got = 1'b0; at = 0; s = '0; m = '0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            bus.generate_next_sample = 1'b0;
            bus.voice_ready          = '0;
            if (bus.new_sample_ready) begin
                got = 1'b1; at = cyc; s = bus.sample_out; m = bus.missed_mask;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.play_enable = 1'b1;
        bus.generate_next_sample = 1'b0;
        bus.voice_active = '0;
        bus.voice_ready = '0;
        bus.voice_samples = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.sample_out !== 16'h0000) begin bad++; $display("FAIL reset_sample_out got=%h exp=0000", bus.sample_out); end
        total++; if (bus.new_sample_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.new_sample_ready); end
        total++; if (bus.missed_mask !== 3'b000) begin bad++; $display("FAIL reset_missed got=%b exp=000", bus.missed_mask); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    endtask

    task automatic test_all_active(input logic pe, input logic [15:0] exp, input string tag);
        int q, at; bit got; logic [15:0] s; logic [2:0] m;
        logic [47:0] smp;
        smp = smp3(16'h4000, 16'h4000, 16'h4000);
        bus.play_enable = pe;
        start_request(3'b111, 3'b000, smp, q);
        present(3'b001, smp);
        present(3'b010, smp);
        present(3'b100, smp);
        wait_pulse(20, got, at, s, m);
        total++; if (!got) begin bad++; $display("FAIL %s_pulse got=none exp=pulse", tag); end
        total++; if (s !== exp) begin bad++; $display("FAIL %s_value got=%h exp=%h", tag, s, exp); end
        total++; if (at - q !== 8) begin bad++; $display("FAIL %s_latency got=%0d exp=8", tag, at - q); end
        total++; if (m !== 3'b000) begin bad++; $display("FAIL %s_missed got=%b exp=000", tag, m); end
        @(negedge clk);
        total++; if (bus.new_sample_ready !== 1'b0) begin bad++; $display("FAIL %s_pulse_width got=%b exp=0", tag, bus.new_sample_ready); end
        total++; if (bus.sample_out !== exp) begin bad++; $display("FAIL %s_hold got=%h exp=%h", tag, bus.sample_out, exp); end
        bus.play_enable = 1'b1;
    endtask

    task automatic test_negative_last_wins();
        int q, at; bit got; logic [15:0] s; logic [2:0] m;
        logic [47:0] neg;
        neg = smp3(16'hFFFC, 16'hFFFC, 16'hFFFC);
        start_request(3'b111, 3'b000, neg, q);
        present(3'b001, smp3(16'h1234, 16'hFFFC, 16'hFFFC));
        present(3'b111, neg);
        present(3'b000, neg);
        present(3'b001, smp3(16'h7FFF, 16'hFFFC, 16'hFFFC));
        wait_pulse(20, got, at, s, m);
        total++; if (!got) begin bad++; $display("FAIL neg_pulse got=none exp=pulse"); end
        total++; if (s !== EXP2) begin bad++; $display("FAIL neg_value got=%h exp=%h", s, EXP2); end
        total++; if (at - q !== 7) begin bad++; $display("FAIL neg_latency got=%0d exp=7", at - q); end
        total++; if (m !== 3'b000) begin bad++; $display("FAIL neg_missed got=%b exp=000", m); end
    endtask

    task automatic test_timeout();
        int q, at; bit got; logic [15:0] s; logic [2:0] m;
        logic [47:0] smp;
        smp = smp3(16'h0800, 16'h0400, 16'h0000);
        start_request(3'b111, 3'b000, smp, q);
        present(3'b011, smp);
        wait_pulse(100, got, at, s, m);
        total++; if (!got) begin bad++; $display("FAIL timeout_pulse got=none exp=pulse"); end
        total++; if (s !== EXP3) begin bad++; $display("FAIL timeout_value got=%h exp=%h", s, EXP3); end
        total++; if (at - q !== 68) begin bad++; $display("FAIL timeout_latency got=%0d exp=68", at - q); end
        total++; if (m !== 3'b100) begin bad++; $display("FAIL timeout_missed got=%b exp=100", m); end
    endtask

    task automatic test_partial_active();
        int q, at; bit got; logic [15:0] s; logic [2:0] m;
        logic [47:0] smp;
        smp = smp3(16'h4000, 16'h7FFC, 16'h0000);
        start_request(3'b010, 3'b000, smp, q);
        present(3'b011, smp);
        wait_pulse(20, got, at, s, m);
        total++; if (!got) begin bad++; $display("FAIL partial_pulse got=none exp=pulse"); end
        total++; if (s !== EXP4) begin bad++; $display("FAIL partial_value got=%h exp=%h", s, EXP4); end
        total++; if (at - q !== 6) begin bad++; $display("FAIL partial_latency got=%0d exp=6", at - q); end
        total++; if (m !== 3'b000) begin bad++; $display("FAIL partial_missed got=%b exp=000", m); end
    endtask

    task automatic test_overrun_and_reset();
        int q, at, extra; bit got; logic [15:0] s; logic [2:0] m;
        logic [47:0] smp;
        smp = smp3(16'h1000, 16'h2000, 16'h3000);
        start_request(3'b111, 3'b111, smp, q);
        present(3'b000, smp);
        present(3'b000, smp);
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        wait_pulse(20, got, at, s, m);
        total++; if (!got) begin bad++; $display("FAIL overrun_pulse got=none exp=pulse"); end
        total++; if (s !== EXP5) begin bad++; $display("FAIL overrun_value got=%h exp=%h", s, EXP5); end
        total++; if (at - q !== 5) begin bad++; $display("FAIL overrun_latency got=%0d exp=5", at - q); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b exp=1", bus.overrun); end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.new_sample_ready) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL overrun_extra_pulses got=%0d exp=0", extra); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b exp=1", bus.overrun); end

        start_request(3'b111, 3'b111, smp, q);
        present(3'b000, smp);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.new_sample_ready !== 1'b0) begin bad++; $display("FAIL midsum_reset_ready got=%b exp=0", bus.new_sample_ready); end
        total++; if (bus.sample_out !== 16'h0000) begin bad++; $display("FAIL midsum_reset_sample got=%h exp=0000", bus.sample_out); end
        total++; if (bus.missed_mask !== 3'b000) begin bad++; $display("FAIL midsum_reset_missed got=%b exp=000", bus.missed_mask); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL midsum_reset_overrun got=%b exp=0", bus.overrun); end
        reset = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.new_sample_ready) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL midsum_reset_pulses got=%0d exp=0", extra); end
    endtask

    initial begin
        test_reset();
        test_all_active(1'b1, EXP1, "all_active");
        test_negative_last_wins();
        test_timeout();
        test_partial_active();
        test_all_active(1'b0, 16'h0000, "play_disabled");
        test_overrun_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
